// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  function automatic int calc_acc_w(input int t, input int k);
    return 2 * t + $clog2(k);
  endfunction

  function automatic int calc_cnt_w(input int k);
    return $clog2(k * k + k + 1);
  endfunction

  // Clamp to the signed out_w range when sat is set; otherwise the caller keeps the low bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc,
                                                   input bit sat, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sat && (acc > hi)) return hi;
    if (sat && (acc < lo)) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/mvm_mac.sv
// Single-stage signed multiply-accumulate; clear starts a new sum with the current product.
module mvm_mac #(
  parameter int T     = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    valid_in,
  input  logic signed [T-1:0]     a,
  input  logic signed [T-1:0]     b,
  output logic signed [ACC_W-1:0] acc,
  output logic                    valid_out
);

  logic signed [2*T-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = (2*T)'(a) * (2*T)'(b);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) acc <= clear ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/mvm_stream_param.sv
// Streaming y = M*x: loads M (optionally reused) and x, runs one pipelined MAC, streams out y.
module mvm_stream_param
  import mvm_pkg::*;
#(
  parameter int K     = 3,
  parameter int T     = 8,
  parameter int OUT_W = 16,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [T-1:0]     data_in,
  input  logic             reuse_m,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] data_out
);

  localparam int ACC_W = calc_acc_w(T, K);
  localparam int CNT_W = calc_cnt_w(K);
  localparam int MA_W  = $clog2(K * K);
  localparam int XA_W  = $clog2(K);
  localparam logic [CNT_W-1:0] MAT_WORDS = CNT_W'(K * K);
  localparam logic [CNT_W-1:0] JOB_LAST  = CNT_W'(K * K + K - 1);
  localparam logic [XA_W-1:0]  K_LAST    = XA_W'(K - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [XA_W-1:0]   r_q, r_d, c_q, c_d, o_ptr_q, o_ptr_d;
  logic              mat_valid_q, mat_valid_d;
  logic              s_ready_q, s_ready_d;

  logic signed [T-1:0]     m_mem [K*K];
  logic signed [T-1:0]     x_mem [K];
  logic signed [T-1:0]     m_rd_q, x_rd_q;
  logic signed [OUT_W-1:0] y_buf [K];

  logic                    rd_vld_q, rd_clr_q, rd_last_q, mac_last_q;
  logic [XA_W-1:0]         rd_row_q, mac_row_q;
  logic signed [ACC_W-1:0] mac_acc;
  logic                    mac_vld;

  logic             s_fire, m_fire, issue, row_done;
  logic [CNT_W-1:0] ld_idx;

  assign s_ready  = s_ready_q;
  assign m_valid  = (state_q == OUTPUT);
  assign data_out = m_valid ? y_buf[o_ptr_q] : '0;
  assign s_fire   = s_valid && s_ready_q;
  assign m_fire   = m_valid && m_ready;
  assign issue    = (state_q == COMPUTE) && (in_cnt_q < MAT_WORDS);
  assign row_done = mac_vld && mac_last_q;

  // A vector-only job simply starts the load index at the first x slot.
  assign ld_idx = ((in_cnt_q == '0) && reuse_m && mat_valid_q) ? MAT_WORDS : in_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      in_cnt_q    <= '0;
      r_q         <= '0;
      c_q         <= '0;
      o_ptr_q     <= '0;
      mat_valid_q <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      r_q         <= r_d;
      c_q         <= c_d;
      o_ptr_q     <= o_ptr_d;
      mat_valid_q <= mat_valid_d;
      s_ready_q   <= s_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    r_d         = r_q;
    c_d         = c_q;
    o_ptr_d     = o_ptr_q;
    mat_valid_d = mat_valid_q;
    s_ready_d   = s_ready_q;
    case (state_q)
      LOAD: begin
        s_ready_d = 1'b1;
        if (s_fire) begin
          if (ld_idx == '0) mat_valid_d = 1'b0;
          if (ld_idx == MAT_WORDS - CNT_W'(1)) mat_valid_d = 1'b1;
          if (ld_idx == JOB_LAST) begin
            state_d   = COMPUTE;
            in_cnt_d  = '0;
            s_ready_d = 1'b0;
          end else begin
            in_cnt_d = ld_idx + CNT_W'(1);
          end
        end
      end
      COMPUTE: begin
        if (issue) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (c_q == K_LAST) begin
            c_d = '0;
            r_d = r_q + XA_W'(1);
          end else begin
            c_d = c_q + XA_W'(1);
          end
        end
        if (row_done && (mac_row_q == K_LAST)) begin
          state_d  = OUTPUT;
          in_cnt_d = '0;
          r_d      = '0;
          c_d      = '0;
        end
      end
      OUTPUT: begin
        if (m_fire) begin
          if (o_ptr_q == K_LAST) begin
            state_d   = LOAD;
            o_ptr_d   = '0;
            s_ready_d = 1'b1;
          end else begin
            o_ptr_d = o_ptr_q + XA_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Block-RAM style storage: one write port from the input stream, registered reads.
  always_ff @(posedge clk) begin
    if (s_fire && (ld_idx < MAT_WORDS)) m_mem[ld_idx[MA_W-1:0]] <= data_in;
    if (s_fire && (ld_idx >= MAT_WORDS)) x_mem[XA_W'(ld_idx - MAT_WORDS)] <= data_in;
    m_rd_q <= m_mem[in_cnt_q[MA_W-1:0]];
    x_rd_q <= x_mem[c_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_clr_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_row_q   <= '0;
      mac_last_q <= 1'b0;
      mac_row_q  <= '0;
    end else begin
      rd_vld_q   <= issue;
      rd_clr_q   <= (c_q == '0);
      rd_last_q  <= (c_q == K_LAST);
      rd_row_q   <= r_q;
      mac_last_q <= rd_vld_q && rd_last_q;
      mac_row_q  <= rd_row_q;
    end
  end

  mvm_mac #(.T(T), .ACC_W(ACC_W)) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear     (rd_clr_q),
    .valid_in  (rd_vld_q),
    .a         (m_rd_q),
    .b         (x_rd_q),
    .acc       (mac_acc),
    .valid_out (mac_vld)
  );

  always_ff @(posedge clk) begin
    if (row_done) y_buf[mac_row_q] <= OUT_W'(sat_trunc(64'(mac_acc), SAT != 0, OUT_W));
  end

endmodule
